// File: rtl/bc_pkg.sv
// Shared types and helpers for the box-counting level scheduler.
// Holds the FSM state encoding, per-level write targets and bank address packing.
package bc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_REPORT,
        ST_DONE
    } bc_state_t;

    // Widest {bank, x, y} address the packing helper supports.
    localparam int BC_ADDR_MAX = 16;

    // Number of boxes the engine writes at a level: 4^(max_box - level).
    function automatic int level_target(input int max_box, input int level);
        return 1 << (2 * (max_box - level));
    endfunction

    // Packs {bank, xy}, where xy occupies the low xy_w bits.
    function automatic logic [BC_ADDR_MAX-1:0] bank_addr(input logic                   bank,
                                                         input logic [BC_ADDR_MAX-2:0] xy,
                                                         input int                     xy_w);
        return {1'b0, xy} | (BC_ADDR_MAX'(bank) << xy_w);
    endfunction

endpackage

// File: rtl/bc_mem_mux.sv
// BC RAM port mux: the host owns the RAM while idle, the engine while busy.
// Engine addresses are steered into the read/write banks chosen by the scheduler.
module bc_mem_mux
    import bc_pkg::*;
#(
    parameter int BOX_IDX = 3,
    parameter int DW      = 8
) (
    input  logic                 busy,
    input  logic                 run,
    input  logic                 rd_bank,
    input  logic                 wr_bank,
    input  logic                 host_we,
    input  logic [2*BOX_IDX:0]   host_addr,
    input  logic [DW-1:0]        host_wdata,
    input  logic                 eng_wen,
    input  logic [DW-1:0]        eng_y,
    input  logic [2*BOX_IDX-1:0] eng_rd_addr,
    input  logic [2*BOX_IDX-1:0] eng_wr_addr,
    output logic                 mem_we,
    output logic [2*BOX_IDX:0]   mem_wr_addr,
    output logic [2*BOX_IDX:0]   mem_rd_addr,
    output logic [DW-1:0]        mem_wdata
);

    localparam int XYW = 2 * BOX_IDX;
    localparam int AW  = XYW + 1;

    always_comb begin
        mem_we      = host_we;
        mem_wr_addr = host_addr;
        mem_rd_addr = host_addr;
        mem_wdata   = host_wdata;
        if (busy) begin
            // Engine writes only land while the level is actually running.
            mem_we      = run & eng_wen;
            mem_wdata   = eng_y;
            mem_rd_addr = AW'(bank_addr(rd_bank, (BC_ADDR_MAX-1)'(eng_rd_addr), XYW));
            mem_wr_addr = AW'(bank_addr(wr_bank, (BC_ADDR_MAX-1)'(eng_wr_addr), XYW));
        end
    end

endmodule

// File: rtl/bc_level_sched.sv
// Level scheduler for the box-counting pyramid: steps the 2x2 grouping engine
// through levels 1..MAX_BOX, ping-ponging banks and reporting nonzero box counts.
module bc_level_sched
    import bc_pkg::*;
#(
    parameter int BOX_IDX = 3,
    parameter int MAX_BOX = 3,
    parameter int DW      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 res_bank,
    output logic                 lvl_valid,
    output logic [BOX_IDX-1:0]   lvl_idx,
    output logic [2*MAX_BOX:0]   lvl_count,
    output logic                 host_gnt,
    input  logic                 host_we,
    input  logic [2*BOX_IDX:0]   host_addr,
    input  logic [DW-1:0]        host_wdata,
    output logic                 bc_mode,
    input  logic                 eng_wen,
    input  logic [DW-1:0]        eng_y,
    input  logic [2*BOX_IDX-1:0] eng_rd_addr,
    input  logic [2*BOX_IDX-1:0] eng_wr_addr,
    output logic                 mem_we,
    output logic [2*BOX_IDX:0]   mem_wr_addr,
    output logic [2*BOX_IDX:0]   mem_rd_addr,
    output logic [DW-1:0]        mem_wdata
);

    localparam int WCW = 2 * MAX_BOX;
    localparam int NCW = 2 * MAX_BOX + 1;

    bc_state_t          state;
    logic [BOX_IDX-1:0] level;
    logic               rd_bank;
    logic               wr_bank;
    logic [WCW-1:0]     wr_cnt;
    logic [NCW-1:0]     nz_cnt;
    logic               last_write;

    assign last_write = eng_wen && (wr_cnt == WCW'(level_target(MAX_BOX, int'(level)) - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            level    <= '0;
            rd_bank  <= 1'b0;
            wr_bank  <= 1'b1;
            res_bank <= 1'b0;
            wr_cnt   <= '0;
            nz_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        level   <= BOX_IDX'(1);
                        rd_bank <= 1'b0;
                        wr_bank <= 1'b1;
                        state   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    wr_cnt <= '0;
                    nz_cnt <= '0;
                    state  <= abort ? ST_IDLE : ST_RUN;
                end
                ST_RUN: begin
                    if (eng_wen) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (eng_y != '0 && nz_cnt != '1)
                            nz_cnt <= nz_cnt + 1'b1;
                    end
                    // Abort takes priority over finishing the level.
                    if (abort)
                        state <= ST_IDLE;
                    else if (last_write)
                        state <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (level == BOX_IDX'(MAX_BOX)) begin
                        res_bank <= wr_bank;
                        state    <= ST_DONE;
                    end else begin
                        level   <= level + 1'b1;
                        rd_bank <= wr_bank;
                        wr_bank <= rd_bank;
                        state   <= ST_INIT;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign lvl_valid = (state == ST_REPORT);
    assign lvl_idx   = level;
    assign lvl_count = nz_cnt;
    assign host_gnt  = !busy;
    assign bc_mode   = (state != ST_RUN);

    bc_mem_mux #(
        .BOX_IDX(BOX_IDX),
        .DW     (DW)
    ) u_mem_mux (
        .busy       (busy),
        .run        (state == ST_RUN),
        .rd_bank    (rd_bank),
        .wr_bank    (wr_bank),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .eng_wen    (eng_wen),
        .eng_y      (eng_y),
        .eng_rd_addr(eng_rd_addr),
        .eng_wr_addr(eng_wr_addr),
        .mem_we     (mem_we),
        .mem_wr_addr(mem_wr_addr),
        .mem_rd_addr(mem_rd_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_bc_level_sched.sv
// Bench for bc_level_sched: RAM and 2x2 summing engine models around the DUT,
// table-driven image runs plus hand sequences for reset, arbitration and abort.
module tb_bc_level_sched;

    localparam int BOX_IDX = 3;
    localparam int MAX_BOX = 3;
    localparam int DW      = 8;
    localparam int XYW     = 2 * BOX_IDX;
    localparam int AW      = XYW + 1;
    localparam int NCW     = 2 * MAX_BOX + 1;
    localparam int RW      = BOX_IDX + NCW;

    logic               CLK;
    logic               RST;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               res_bank;
    logic               lvl_valid;
    logic [BOX_IDX-1:0] lvl_idx;
    logic [NCW-1:0]     lvl_count;
    logic               host_gnt;
    logic               host_we;
    logic [AW-1:0]      host_addr;
    logic [DW-1:0]      host_wdata;
    logic               bc_mode;
    logic               eng_wen;
    logic [DW-1:0]      eng_y;
    logic [XYW-1:0]     eng_rd_addr;
    logic [XYW-1:0]     eng_wr_addr;
    logic               mem_we;
    logic [AW-1:0]      mem_wr_addr;
    logic [AW-1:0]      mem_rd_addr;
    logic [DW-1:0]      mem_wdata;

    bc_level_sched #(
        .BOX_IDX(BOX_IDX),
        .MAX_BOX(MAX_BOX),
        .DW     (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .res_bank   (res_bank),
        .lvl_valid  (lvl_valid),
        .lvl_idx    (lvl_idx),
        .lvl_count  (lvl_count),
        .host_gnt   (host_gnt),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .bc_mode    (bc_mode),
        .eng_wen    (eng_wen),
        .eng_y      (eng_y),
        .eng_rd_addr(eng_rd_addr),
        .eng_wr_addr(eng_wr_addr),
        .mem_we     (mem_we),
        .mem_wr_addr(mem_wr_addr),
        .mem_rd_addr(mem_rd_addr),
        .mem_wdata  (mem_wdata)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // BC RAM model
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (mem_we) ram[mem_wr_addr] <= mem_wdata;
    end

    // scoreboard: expected vs observed {lvl_idx, lvl_count} reports
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] obs_q[$];
    int done_cnt    = 0;
    int overlap_cnt = 0;
    int n_total     = 0;
    int n_bad       = 0;

    always @(negedge CLK) begin
        if (lvl_valid) obs_q.push_back({lvl_idx, lvl_count});
        if (done) done_cnt <= done_cnt + 1;
        if (lvl_valid && mem_we) overlap_cnt <= overlap_cnt + 1;
    end

    typedef struct {
        logic [DW-1:0] fill;
        logic [DW-1:0] p00;
        int            c1;
        int            c2;
        int            c3;
        int            final_v;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_addr  = a;
        host_wdata = d;
        host_we    = 1'b1;
        @(posedge CLK); #1;
        host_we    = 1'b0;
    endtask

    task automatic load_image(input logic [DW-1:0] fill, input logic [DW-1:0] p00);
        for (int a = 0; a < (1 << XYW); a++)
            host_write(AW'(a), (a == 0) ? p00 : fill);
    endtask

    // Engine model for one level; abort_at >= 0 aborts on that write index.
    task automatic run_level(input int lvl, input int abort_at, output bit ok);
        int n;
        int side;
        int idx;
        int sum;
        bit exp_rd;
        n = 0;
        while (bc_mode && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        if (bc_mode) begin
            check("run_wait_timeout", 0, 1);
            ok = 1'b0;
            return;
        end
        side   = 1 << (MAX_BOX - lvl);
        idx    = 0;
        exp_rd = (lvl % 2 == 0);
        for (int i = 0; i < side; i++) begin
            for (int j = 0; j < side; j++) begin
                eng_wen = 1'b0;
                sum = 0;
                for (int dx = 0; dx < 2; dx++) begin
                    for (int dy = 0; dy < 2; dy++) begin
                        eng_rd_addr = {BOX_IDX'(2*i+dx), BOX_IDX'(2*j+dy)};
                        #1;
                        sum += int'(ram[mem_rd_addr]);
                    end
                end
                eng_wen     = 1'b1;
                eng_y       = DW'(sum);
                eng_wr_addr = {BOX_IDX'(i), BOX_IDX'(j)};
                #1;
                if (idx == 0) begin
                    check("bank_rd_msb", mem_rd_addr[AW-1], exp_rd);
                    check("bank_wr_msb", mem_wr_addr[AW-1], !exp_rd);
                end
                if (idx == abort_at) abort = 1'b1;
                @(posedge CLK); #1;
                abort = 1'b0;
                if (idx == abort_at) begin
                    eng_wen = 1'b0;
                    ok = 1'b1;
                    return;
                end
                idx++;
            end
        end
        eng_wen = 1'b0;
        ok = 1'b1;
    endtask

    task automatic compare_reports();
        logic [RW-1:0] e;
        logic [RW-1:0] o;
        check("report_num", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("report_idx", int'(o[RW-1:NCW]), int'(e[RW-1:NCW]));
            check("report_cnt", int'(o[NCW-1:0]), int'(e[NCW-1:0]));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic run_full(input int c1, input int c2, input int c3,
                            input bit hold, input bit host_poke);
        int base;
        int n;
        bit ok;
        exp_q.push_back({BOX_IDX'(1), NCW'(c1)});
        exp_q.push_back({BOX_IDX'(2), NCW'(c2)});
        exp_q.push_back({BOX_IDX'(3), NCW'(c3)});
        base  = done_cnt;
        start = 1'b1;
        @(posedge CLK); #1;
        if (!hold) start = 1'b0;
        check("start_busy", busy, 1);
        if (host_poke) begin
            host_addr  = AW'(63);
            host_wdata = 8'hAA;
            host_we    = 1'b1;
        end
        ok = 1'b1;
        for (int lvl = 1; lvl <= MAX_BOX && ok; lvl++) begin
            run_level(lvl, -1, ok);
            if (host_poke) begin
                check("host_gnt_busy", host_gnt, 0);
                check("host_we_blocked", mem_we, 0);
            end
        end
        n = 0;
        while (!done && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        check("done_latency", n, 1);
        check("res_bank", res_bank, 1);
        start   = 1'b0;
        host_we = 1'b0;
        @(posedge CLK); #1;
        check("done_pulse", done, 0);
        check("idle_after_done", busy, 0);
        repeat (2) @(posedge CLK);
        #1;
        check("single_run", busy, 0);
        check("done_count", done_cnt - base, 1);
        compare_reports();
    endtask

    initial begin
        int n;
        int base;
        bit ok;
        vecs[0] = '{fill: 8'd1, p00: 8'd1, c1: 16, c2: 4, c3: 1, final_v: 64};
        vecs[1] = '{fill: 8'd0, p00: 8'd5, c1: 1,  c2: 1, c3: 1, final_v: 5};
        vecs[2] = '{fill: 8'd0, p00: 8'd0, c1: 0,  c2: 0, c3: 0, final_v: 0};
        vecs[3] = '{fill: 8'd2, p00: 8'd2, c1: 16, c2: 4, c3: 1, final_v: 128};

        RST = 1'b1; start = 1'b0; abort = 1'b0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        eng_wen = 1'b0; eng_y = '0; eng_rd_addr = '0; eng_wr_addr = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bc_mode", bc_mode, 1);
        check("rst_host_gnt", host_gnt, 1);
        check("rst_done", done, 0);
        check("rst_lvl_valid", lvl_valid, 0);
        check("rst_res_bank", res_bank, 0);
        check("rst_lvl_count", lvl_count, 0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // reset in the middle of a run
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        n = 0;
        while (bc_mode && n < 20) begin
            @(posedge CLK); #1;
            n++;
        end
        check("mid_rst_in_run", bc_mode, 0);
        eng_wen = 1'b1; eng_y = 8'd3;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        eng_wen = 1'b0;
        @(posedge CLK); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_bc_mode", bc_mode, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_lvl_valid", lvl_valid, 0);
        check("mid_rst_wr_bank", dut.wr_bank, 1);
        check("mid_rst_lvl_count", lvl_count, 0);
        RST = 1'b0;
        @(posedge CLK); #1;
        obs_q.delete();

        // table of images
        for (int v = 0; v < 4; v++) begin
            load_image(vecs[v].fill, vecs[v].p00);
            run_full(vecs[v].c1, vecs[v].c2, vecs[v].c3, 1'b0, 1'b0);
            check("final_box", int'(ram[AW'(1 << XYW)]), vecs[v].final_v);
        end

        // host write attempted during a run, start held high throughout
        load_image(8'd1, 8'd1);
        run_full(16, 4, 1, 1'b1, 1'b1);
        check("host_no_write", int'(ram[AW'(63)]), 1);
        check("arb_final_box", int'(ram[AW'(1 << XYW)]), 64);

        // abort on the 10th level-1 write; that write still lands
        host_write(AW'(81), 8'd0);
        base = done_cnt;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        run_level(1, 9, ok);
        check("abort_idle", busy, 0);
        check("abort_bc_mode", bc_mode, 1);
        repeat (3) @(posedge CLK);
        #1;
        check("abort_write_kept", int'(ram[AW'(81)]), 4);
        check("abort_no_report", obs_q.size(), 0);
        check("abort_no_done", done_cnt - base, 0);
        obs_q.delete();
        run_full(16, 4, 1, 1'b0, 1'b0);

        check("report_write_overlap", overlap_cnt, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
